// File: rtl/mem_sp_pipe.sv
// mem_sp_pipe: parametrised single-port RAM with byte enables and a 1/2-cycle read pipeline.
// Optional post-reset clear sweep is built when MEM_SP_PIPE_CLEAR_EN is defined.
module mem_sp_pipe #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 14,
    parameter int RD_LAT = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                clka,
    input  logic                rsta,
    input  logic                reqa,
    input  logic [DATA_W/8-1:0] wea,
    input  logic [ADDR_W-1:0]   addra,
    input  logic [DATA_W-1:0]   dina,
    output logic [DATA_W-1:0]   douta,
    output logic                valida,
    output logic                readya
);
    localparam int NB = DATA_W / 8;
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    logic [0:0]        state_q, state_d;
    logic              clr_wr;
    logic [ADDR_W-1:0] clr_idx;
    logic              accept;
    logic              rd_acc;
    logic [NB-1:0]     wr_be;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_v_q, rd_v_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              v1_q, v1_d;
    logic [DATA_W-1:0] d1_q, d1_d;

    assign readya = (state_q == ST_READY) & ~rsta;
    assign accept = reqa & readya;
    assign rd_acc = accept & ~(|wea);

`ifdef MEM_SP_PIPE_CLEAR_EN
    localparam logic [ADDR_W:0] CLR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0] clr_addr_q, clr_addr_d;

    assign clr_idx = clr_addr_q[ADDR_W-1:0];

    // Sweep FSM: write INIT_VAL to every word, then open for requests
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_wr     = 1'b0;
        if (state_q == ST_CLEAR && !rsta) begin
            if (clr_addr_q[ADDR_W]) begin
                state_d = ST_READY;
            end else begin
                clr_wr     = 1'b1;
                clr_addr_d = clr_addr_q + CLR_ONE;
            end
        end
    end

    // Sweep state and counter; reset restarts the sweep
    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end
`else
    assign clr_idx = '0;

    // No sweep: the block is ready as soon as reset drops
    always_comb begin
        state_d = ST_READY;
        clr_wr  = 1'b0;
    end

    // Ready state register
    always_ff @(posedge clka) begin
        if (rsta) state_q <= ST_READY;
        else      state_q <= state_d;
    end
`endif

    // Write port mux: sweep has priority, requests only land when ready
    always_comb begin
        wr_be   = '0;
        wr_addr = addra;
        wr_data = dina;
        if (clr_wr) begin
            wr_be   = '1;
            wr_addr = clr_idx;
            wr_data = INIT_VAL;
        end else if (accept) begin
            wr_be = wea;
        end
    end

    // Byte-lane write into the array
    always_ff @(posedge clka) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_be[i]) mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
    end

    // Read stage 1: register address, then data one edge later
    always_comb begin
        rd_v_d    = rd_acc;
        rd_addr_d = rd_acc ? addra : rd_addr_q;
        v1_d      = rd_v_q;
        d1_d      = rd_v_q ? mem_q[rd_addr_q] : d1_q;
    end

    // Read pipeline registers; reset flushes reads in flight
    always_ff @(posedge clka) begin
        if (rsta) begin
            rd_v_q    <= 1'b0;
            rd_addr_q <= '0;
            v1_q      <= 1'b0;
            d1_q      <= '0;
        end else begin
            rd_v_q    <= rd_v_d;
            rd_addr_q <= rd_addr_d;
            v1_q      <= v1_d;
            d1_q      <= d1_d;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              v2_q, v2_d;
            logic [DATA_W-1:0] d2_q, d2_d;

            // Output stage: valid travels with its data
            always_comb begin
                v2_d = v1_q;
                d2_d = v1_q ? d1_q : d2_q;
            end

            // Output stage registers
            always_ff @(posedge clka) begin
                if (rsta) begin
                    v2_q <= 1'b0;
                    d2_q <= '0;
                end else begin
                    v2_q <= v2_d;
                    d2_q <= d2_d;
                end
            end

            assign douta  = d2_q;
            assign valida = v2_q;
        end else begin : g_lat1
            assign douta  = d1_q;
            assign valida = v1_q;
        end
    endgenerate
endmodule
